mult_seq_4bit: RTL and testbench



---
 rtl/mult_seq_4bit_pkg.sv | 14 +
 rtl/mult_seq_4bit_if.sv | 15 +
 rtl/rca_4bit.sv | 21 ++
 rtl/mult_seq_4bit.sv | 99 +++++++++
 tb/tb_mult_seq_4bit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_seq_4bit_pkg.sv
// Shared types and widths for the sequential 4x4 shift-and-add multiplier.
package mult_seq_pkg;

  localparam int W     = 4;
  localparam int STEPS = 4;
  localparam int PW    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_4bit_if.sv
// Operand/result handshake bundle: master issues start/a/b, slave returns busy/done/p.
interface mult_seq_4bit_if;
  import mult_seq_pkg::*;

  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder; purely combinational, no backpressure.
module rca_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/mult_seq_4bit.sv
// Sequential 4x4 unsigned multiplier; product and done 5 cycles after accepted start.
// start is accepted only in IDLE/DONE and ignored while busy; MULT_ZERO_BYPASS_EN finishes zero operands in 1 cycle.
module mult_seq_4bit
  import mult_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mult_seq_4bit_if.slave  bus
);

  state_t        state;
  logic [W-1:0]  m;
  logic [W-1:0]  acc;
  logic [W-1:0]  q;
  logic [1:0]    cnt;
  logic          busy_r;
  logic          done_r;
  logic [PW-1:0] p_r;

  logic [W-1:0]  addend;
  logic [W-1:0]  sum;
  logic          cout;
  logic [PW-1:0] step_next;

  assign addend    = q[0] ? m : '0;
  // carry-out lands in acc[3] after the shift, so the 9th sum bit is never dropped
  assign step_next = {cout, sum, q[W-1:1]};

  rca_4bit u_rca (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      m      <= '0;
      acc    <= '0;
      q      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      p_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            m   <= bus.a;
            acc <= '0;
            q   <= bus.b;
            cnt <= '0;
`ifdef MULT_ZERO_BYPASS_EN
            if ((bus.a == '0) || (bus.b == '0)) begin
              state  <= DONE;
              p_r    <= '0;
              done_r <= 1'b1;
              busy_r <= 1'b0;
            end else begin
              state  <= CALC;
              busy_r <= 1'b1;
            end
`else
            state  <= CALC;
            busy_r <= 1'b1;
`endif
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end

        CALC: begin
          {acc, q} <= step_next;
          cnt      <= cnt + 2'd1;
          if (cnt == 2'(STEPS - 1)) begin
            p_r    <= step_next;
            state  <= DONE;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.p    = p_r;

endmodule

// File: tb/tb_mult_seq_4bit.sv
// Directed self-checking bench for mult_seq_4bit: latency, handshake, abort and exhaustive products.
module tb_mult_seq_4bit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_seen;
  bit   count_en;

  mult_seq_4bit_if bus ();

  mult_seq_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (count_en && bus.done === 1'b1) done_seen++;
  end

  // Samples once per cycle (#1 after the edge) until done, bounded at 20 cycles.
  // lat counts edges since acceptance (1 = the cycle right after the accepting edge); -1 on timeout.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat <= 20) begin
      if (bus.busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat > 20) lat = -1;
  endtask

  task automatic issue(input logic [3:0] ia, input logic [3:0] ib);
    bus.start = 1'b1;
    bus.a = ia;
    bus.b = ib;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    int lat, bn;
    checks++; if (bus.p !== 8'h00) begin errors++; $display("FAIL reset_p got %0d want 0", bus.p); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    issue(4'd2, 4'd3);
    wait_done(lat, bn);
    checks++; if (bus.p !== 8'd6) begin errors++; $display("FAIL pre_reset_p got %0d want 6", bus.p); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.p !== 8'h00) begin errors++; $display("FAIL async_reset_p got %0d want 0", bus.p); end
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL async_reset_ctl got done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_scale;
    int lat, bn;
    issue(4'd15, 4'd15);
    wait_done(lat, bn);
    checks++; if (lat !== 5) begin errors++; $display("FAIL fs_latency got %0d want 5", lat); end
    checks++; if (bn !== 4) begin errors++; $display("FAIL fs_busy_cycles got %0d want 4", bn); end
    checks++; if (bus.p !== 8'd225) begin errors++; $display("FAIL fs_product got %0d want 225", bus.p); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL fs_done_pulse got %b want 0", bus.done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.p !== 8'd225) begin errors++; $display("FAIL fs_hold got %0d want 225", bus.p); end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    bus.start = 1'b1;
    bus.a = 4'd9;
    bus.b = 4'd6;
    @(posedge clk); #1;
    wait_done(lat, bn);
    checks++; if (lat !== 5) begin errors++; $display("FAIL held_latency got %0d want 5", lat); end
    checks++; if (bus.p !== 8'd54) begin errors++; $display("FAIL held_product got %0d want 54", bus.p); end
    bus.a = 4'd3;
    bus.b = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL done_accept got done=%b busy=%b want 0/1", bus.done, bus.busy);
    end
    checks++; if (bus.p !== 8'd54) begin errors++; $display("FAIL b2b_hold got %0d want 54", bus.p); end
    wait_done(lat, bn);
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lat); end
    checks++; if (bus.p !== 8'd15) begin errors++; $display("FAIL b2b_product got %0d want 15", bus.p); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int lat, bn, dn;
    issue(4'd7, 4'd11);
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.p !== 8'h00) begin
      errors++; $display("FAIL abort_reset got busy=%b p=%0d want 0/0", bus.busy, bus.p);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
      @(posedge clk); #1;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_idle got %0d active cycles want 0", dn); end
    checks++; if (bus.p !== 8'h00) begin errors++; $display("FAIL abort_p got %0d want 0", bus.p); end
    issue(4'd7, 4'd11);
    wait_done(lat, bn);
    checks++; if (lat !== 5) begin errors++; $display("FAIL restart_latency got %0d want 5", lat); end
    checks++; if (bus.p !== 8'd77) begin errors++; $display("FAIL restart_product got %0d want 77", bus.p); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int lat, bn, want_lat, want_busy;
`ifdef MULT_ZERO_BYPASS_EN
    want_lat = 1;
    want_busy = 0;
`else
    want_lat = 5;
    want_busy = 4;
`endif
    issue(4'd5, 4'd5);
    wait_done(lat, bn);
    @(posedge clk); #1;
    issue(4'd0, 4'd13);
    wait_done(lat, bn);
    checks++; if (lat !== want_lat) begin errors++; $display("FAIL zero_a_latency got %0d want %0d", lat, want_lat); end
    checks++; if (bn !== want_busy) begin errors++; $display("FAIL zero_a_busy got %0d want %0d", bn, want_busy); end
    checks++; if (bus.p !== 8'h00) begin errors++; $display("FAIL zero_a_product got %0d want 0", bus.p); end
    @(posedge clk); #1;
    issue(4'd13, 4'd0);
    wait_done(lat, bn);
    checks++; if (lat !== want_lat) begin errors++; $display("FAIL zero_b_latency got %0d want %0d", lat, want_lat); end
    checks++; if (bus.p !== 8'h00) begin errors++; $display("FAIL zero_b_product got %0d want 0", bus.p); end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive;
    int lat, bn;
    logic [3:0] pa, pb;
    logic [7:0] want;
    done_seen = 0;
    count_en = 1'b1;
    pa = 4'd0;
    pb = 4'd0;
    bus.start = 1'b1;
    bus.a = pa;
    bus.b = pb;
    @(posedge clk); #1;
    for (int i = 1; i <= 256; i++) begin
      wait_done(lat, bn);
      want = pa * pb;
      checks++; if (lat < 0 || bus.p !== want) begin
        errors++; $display("FAIL exh_%0d_x_%0d got %0d want %0d (lat %0d)", pa, pb, bus.p, want, lat);
      end
      if (i < 256) begin
        pa = 4'(i % 16);
        pb = 4'(i / 16);
        bus.a = pa;
        bus.b = pb;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    count_en = 1'b0;
    checks++; if (done_seen !== 256) begin errors++; $display("FAIL exh_done_count got %0d want 256", done_seen); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    done_seen = 0;
    count_en = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 4'd0;
    bus.b = 4'd0;
    #1;
    test_reset_pre: begin end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_full_scale();
    test_back_to_back();
    test_abort();
    test_zero();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
